// File: rtl/equalization_sequencer.sv
// Phase sequencer for the histogram-equalization pipeline: clears the histogram
// bins, then launches histogram, CDF and mapping units in turn with a per-phase watchdog.
module equalization_sequencer #(
  parameter int BINS           = 256,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH  = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_equalization,
  input  logic                  abort,
  input  logic                  histogram_done,
  input  logic                  cdf_done,
  input  logic                  mapping_done,
  output logic                  start_histogram,
  output logic                  start_cdf,
  output logic                  start_mapping,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_address,
  output logic                  busy,
  output logic                  equalization_done,
  output logic                  timeout_error,
  output logic [2:0]            phase
);

  // Handshake: each start_* is a single-cycle pulse issued from its START state;
  // the matching *_done is a single-cycle pulse honoured only in the WAIT state
  // that follows. Done pulses seen in any other state are dropped, not remembered.
  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_HIST_START,
    S_HIST_WAIT,
    S_CDF_START,
    S_CDF_WAIT,
    S_MAP_START,
    S_MAP_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR = ADDR_WIDTH'(BINS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT  =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic                     WD_EN     = (TIMEOUT_CYCLES != 0);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   clear_count;
  logic [TIMEOUT_WIDTH-1:0] wd_count;
  logic                    in_wait;
  logic                    wait_done;
  logic                    timed_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      clear_count <= '0;
      wd_count    <= '0;
    end else begin
      state <= next_state;
      // Counters run only while the FSM stays in the same state; any exit
      // (including abort) returns them to zero for the next entry.
      if (state == S_CLEAR && next_state == S_CLEAR)
        clear_count <= clear_count + 1'b1;
      else
        clear_count <= '0;
      if (in_wait && next_state == state)
        wd_count <= wd_count + 1'b1;
      else
        wd_count <= '0;
    end
  end

  always_comb begin
    in_wait   = 1'b0;
    wait_done = 1'b0;
    case (state)
      S_HIST_WAIT: begin in_wait = 1'b1; wait_done = histogram_done; end
      S_CDF_WAIT:  begin in_wait = 1'b1; wait_done = cdf_done;       end
      S_MAP_WAIT:  begin in_wait = 1'b1; wait_done = mapping_done;   end
      default:     begin in_wait = 1'b0; wait_done = 1'b0;           end
    endcase
    timed_out = WD_EN && in_wait && !wait_done && (wd_count == WD_LIMIT);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (start_equalization) next_state = S_CLEAR;
      S_CLEAR:      if (clear_count == LAST_ADDR) next_state = S_HIST_START;
      S_HIST_START: next_state = S_HIST_WAIT;
      S_HIST_WAIT:  if (wait_done) next_state = S_CDF_START;
      S_CDF_START:  next_state = S_CDF_WAIT;
      S_CDF_WAIT:   if (wait_done) next_state = S_MAP_START;
      S_MAP_START:  next_state = S_MAP_WAIT;
      S_MAP_WAIT:   if (wait_done) next_state = S_DONE;
      S_DONE:       next_state = S_IDLE;
      S_ERROR:      if (start_equalization) next_state = S_CLEAR;
      default:      next_state = S_IDLE;
    endcase
    if (timed_out) next_state = S_ERROR;
    // Abort outranks start, done and timeout alike.
    if (abort) next_state = S_IDLE;
  end

  always_comb begin
    start_histogram   = (state == S_HIST_START);
    start_cdf         = (state == S_CDF_START);
    start_mapping     = (state == S_MAP_START);
    clear_we          = (state == S_CLEAR);
    clear_address     = (state == S_CLEAR) ? clear_count : '0;
    busy              = (state != S_IDLE) && (state != S_ERROR);
    equalization_done = (state == S_DONE);
    timeout_error     = (state == S_ERROR);
    case (state)
      S_IDLE:                    phase = 3'd0;
      S_CLEAR:                   phase = 3'd1;
      S_HIST_START, S_HIST_WAIT: phase = 3'd2;
      S_CDF_START, S_CDF_WAIT:   phase = 3'd3;
      S_MAP_START, S_MAP_WAIT:   phase = 3'd4;
      S_DONE:                    phase = 3'd5;
      S_ERROR:                   phase = 3'd7;
      default:                   phase = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_equalization_sequencer.sv
// Directed bench for equalization_sequencer: each step drives inputs, queues the
// expected output snapshot, and compares it after the next rising edge.
module tb_equalization_sequencer;

  localparam int W = 18;

  // Input bundle order: {start_equalization, abort, histogram_done, cdf_done, mapping_done}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] ST   = 5'b10000;
  localparam logic [4:0] AB   = 5'b01000;
  localparam logic [4:0] HD   = 5'b00100;
  localparam logic [4:0] CD   = 5'b00010;
  localparam logic [4:0] MD   = 5'b00001;

  // Snapshot order: {busy, timeout_error, eq_done, start_map, start_cdf, start_hist, clear_we, addr[7:0], phase}
  localparam logic [W-1:0] IDLE_V = {1'b0, 1'b0, 4'b0000, 1'b0, 8'd0, 3'd0};
  localparam logic [W-1:0] HS_V   = {1'b1, 1'b0, 4'b0001, 1'b0, 8'd0, 3'd2};
  localparam logic [W-1:0] HW_V   = {1'b1, 1'b0, 4'b0000, 1'b0, 8'd0, 3'd2};
  localparam logic [W-1:0] CS_V   = {1'b1, 1'b0, 4'b0010, 1'b0, 8'd0, 3'd3};
  localparam logic [W-1:0] CW_V   = {1'b1, 1'b0, 4'b0000, 1'b0, 8'd0, 3'd3};
  localparam logic [W-1:0] MS_V   = {1'b1, 1'b0, 4'b0100, 1'b0, 8'd0, 3'd4};
  localparam logic [W-1:0] MW_V   = {1'b1, 1'b0, 4'b0000, 1'b0, 8'd0, 3'd4};
  localparam logic [W-1:0] DN_V   = {1'b1, 1'b0, 4'b1000, 1'b0, 8'd0, 3'd5};
  localparam logic [W-1:0] ER_V   = {1'b0, 1'b1, 4'b0000, 1'b0, 8'd0, 3'd7};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_equalization = 1'b0;
  logic       abort = 1'b0;
  logic       histogram_done = 1'b0;
  logic       cdf_done = 1'b0;
  logic       mapping_done = 1'b0;
  logic       start_histogram;
  logic       start_cdf;
  logic       start_mapping;
  logic       clear_we;
  logic [7:0] clear_address;
  logic       busy;
  logic       equalization_done;
  logic       timeout_error;
  logic [2:0] phase;
  logic [W-1:0] obs;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // clock/reset
  always #5 clock = ~clock;

  equalization_sequencer #(
    .BINS(8),
    .ADDR_WIDTH(8),
    .TIMEOUT_WIDTH(20),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_equalization(start_equalization),
    .abort(abort),
    .histogram_done(histogram_done),
    .cdf_done(cdf_done),
    .mapping_done(mapping_done),
    .start_histogram(start_histogram),
    .start_cdf(start_cdf),
    .start_mapping(start_mapping),
    .clear_we(clear_we),
    .clear_address(clear_address),
    .busy(busy),
    .equalization_done(equalization_done),
    .timeout_error(timeout_error),
    .phase(phase)
  );

  assign obs = {busy, timeout_error, equalization_done, start_mapping, start_cdf,
                start_histogram, clear_we, clear_address, phase};

  function automatic logic [W-1:0] clr(input int a);
    logic [7:0] addr;
    addr = 8'(a);
    return {1'b1, 1'b0, 4'b0000, 1'b1, addr, 3'd1};
  endfunction

  // scoreboard
  task automatic compare(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    compare(tag);
  endtask

  // driver
  task automatic step(input string tag, input logic [4:0] in, input logic [W-1:0] e);
    {start_equalization, abort, histogram_done, cdf_done, mapping_done} = in;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  task automatic waits(input string tag, input int n, input logic [W-1:0] e);
    for (int i = 0; i < n; i++) step(tag, NONE, e);
  endtask

  // Start pulse, eight clear cycles at addresses 0..7, then the histogram launch.
  // 'stray' is driven during the address-3 cycle.
  task automatic run_clear(input logic [4:0] stray);
    step("clear_addr0", ST, clr(0));
    for (int i = 1; i < 8; i++) step("clear_addr", (i == 4) ? stray : NONE, clr(i));
    step("hist_start", NONE, HS_V);
  endtask

  initial begin
    #2;
    check_now("reset_state", IDLE_V);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("idle_abort_noop", AB, IDLE_V);
    step("idle_hold", NONE, IDLE_V);

    // Full run with done latencies 5 / 3 / 4
    run_clear(NONE);
    waits("hist_wait", 5, HW_V);
    step("cdf_start", HD, CS_V);
    waits("cdf_wait", 3, CW_V);
    step("map_start", CD, MS_V);
    waits("map_wait", 4, MW_V);
    step("eq_done", MD, DN_V);
    step("done_ignores_start", ST, IDLE_V);
    step("idle_after_done", NONE, IDLE_V);

    // CDF timeout after exactly 16 wait cycles
    run_clear(NONE);
    step("hist_wait", NONE, HW_V);
    step("cdf_start", HD, CS_V);
    waits("cdf_wait_to", 16, CW_V);
    step("cdf_timeout", NONE, ER_V);
    step("error_hold", NONE, ER_V);

    // Restart from ERROR; cdf_done on the 16th wait cycle wins over timeout
    run_clear(NONE);
    step("hist_wait", NONE, HW_V);
    step("cdf_start", HD, CS_V);
    waits("cdf_wait_a", 7, CW_V);
    step("stray_map_done", MD, CW_V);
    waits("cdf_wait_b", 8, CW_V);
    step("cdf_done_at_limit", CD, MS_V);
    waits("map_wait", 2, MW_V);
    step("abort_map_wait", AB, IDLE_V);
    step("idle_after_abort", NONE, IDLE_V);

    // Stray histogram_done in CLEAR and in HIST_START, then histogram timeout
    run_clear(HD);
    step("stray_hist_start", HD, HW_V);
    waits("hist_wait_hold", 15, HW_V);
    step("hist_timeout", NONE, ER_V);
    step("abort_beats_start", ST | AB, IDLE_V);
    step("idle_after_err_abort", NONE, IDLE_V);

    // Abort during CLEAR at address 3
    step("clear_addr0", ST, clr(0));
    step("clear_addr1", NONE, clr(1));
    step("clear_addr2", NONE, clr(2));
    step("clear_addr3", NONE, clr(3));
    step("abort_clear", AB, IDLE_V);
    step("idle_after_clear_abort", NONE, IDLE_V);

    // Asynchronous reset mid HIST_WAIT, then a fresh run
    run_clear(NONE);
    waits("hist_wait", 2, HW_V);
    #3;
    reset = 1'b1;
    #1;
    check_now("async_reset", IDLE_V);
    @(posedge clock);
    #1;
    check_now("reset_held", IDLE_V);
    reset = 1'b0;
    run_clear(NONE);
    step("hist_wait_after_reset", NONE, HW_V);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/equalization_sequencer.md
Name: equalization_sequencer

Overview:
Top-level phase sequencer for the histogram-equalization pipeline. It first clears the scratch-memory histogram bins. It then launches and waits on three units in turn: the histogram unit, the CDF unit and the pixel-mapping unit, using start-pulse / done-pulse handshakes. A per-phase watchdog detects a hung unit, and an abort returns the pipeline to idle.

Parameters:
BINS, 256, number of histogram bins cleared in scratch memory
ADDR_WIDTH, 8, scratch-memory address width; must satisfy 2^ADDR_WIDTH >= BINS
TIMEOUT_WIDTH, 20, width of the watchdog counter
TIMEOUT_CYCLES, 1000000, maximum cycles allowed in any wait state; 0 disables the watchdog

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE and all outputs to reset values
start_equalization  input  1  request a full equalization run; sampled in IDLE and ERROR only
abort  input  1  synchronous abort; sampled in every state
histogram_done  input  1  one-cycle done pulse from the histogram unit
cdf_done  input  1  one-cycle done pulse from the CDF unit
mapping_done  input  1  one-cycle done pulse from the mapping unit
start_histogram  output  1  one-cycle launch pulse to the histogram unit
start_cdf  output  1  one-cycle launch pulse to the CDF unit
start_mapping  output  1  one-cycle launch pulse to the mapping unit
clear_we  output  1  scratch-memory write enable during the clear phase (write data is 0)
clear_address  output  ADDR_WIDTH  scratch-memory address during the clear phase
busy  output  1  high in every state except IDLE and ERROR
equalization_done  output  1  one-cycle pulse when the mapping phase completes
timeout_error  output  1  high while in ERROR
phase  output  3  0 idle, 1 clear, 2 histogram, 3 cdf, 4 mapping, 5 done, 7 error

Behaviour:
- Moore machine: every output decodes from the state register and counters only, with no combinational input-to-output path.
- Reset values: state IDLE, every 1-bit output 0, clear_address 0, phase 0, both counters 0.
- States and transitions:
  - IDLE: start_equalization=1 -> CLEAR; otherwise stay.
  - CLEAR: clear_we=1 and clear_address=clear counter. The counter starts at 0 and increments each cycle. When the counter equals BINS-1, the next state is HIST_START. Exactly BINS write cycles occur, covering addresses 0..BINS-1 in order.
  - HIST_START: start_histogram=1 for exactly one cycle -> HIST_WAIT.
  - HIST_WAIT: histogram_done=1 -> CDF_START.
  - CDF_START: start_cdf=1 for one cycle -> CDF_WAIT.
  - CDF_WAIT: cdf_done=1 -> MAP_START.
  - MAP_START: start_mapping=1 for one cycle -> MAP_WAIT.
  - MAP_WAIT: mapping_done=1 -> DONE.
  - DONE: equalization_done=1 for one cycle -> IDLE. start_equalization is ignored in DONE.
  - ERROR: timeout_error=1. start_equalization=1 -> CLEAR. Otherwise stay.
- Latency: start_equalization high at cycle t gives clear_we high in cycles t+1..t+BINS and start_histogram high at t+BINS+1. A done pulse at cycle u in a WAIT state gives the next start pulse (or equalization_done) at u+1.
- Done inputs are honoured only in their own WAIT state. A done pulse arriving in any other state, including that phase's START cycle, is ignored and is not remembered.
- Watchdog:
  - The watchdog counter clears to 0 on entry to each WAIT state and increments every cycle spent in WAIT.
  - If TIMEOUT_CYCLES != 0, the counter equals TIMEOUT_CYCLES-1 and the matching done is low, the next state is ERROR. The unit therefore gets exactly TIMEOUT_CYCLES cycles in WAIT.
  - Done and timeout in the same cycle: done wins.
  - TIMEOUT_CYCLES must fit in TIMEOUT_WIDTH bits.
- Abort:
  - abort=1 in any state -> IDLE on the next edge. Both counters clear and no equalization_done is issued.
  - abort has priority over start_equalization, done inputs and the timeout.
  - abort in IDLE has no effect.
  - An abort during CLEAR leaves the scratch memory partially cleared; the next run re-clears all bins.
- Asynchronous reset mid-run: immediate return to reset values with no pulses emitted. A start pulse is never stretched or repeated across reset.
- At most one start_* pulse or equalization_done is high in any cycle.

Test Plan:
- BINS=8, TIMEOUT_CYCLES=16. Pulse start at t=0 -> clear_we high t=1..8 with addresses 0..7, start_histogram at t=9, phase=2, busy=1.
- Full run: return histogram_done 5 cycles after start_histogram, cdf_done after 3 cycles, mapping_done after 4 cycles. Each next start pulse follows its done by exactly 1 cycle; equalization_done fires once, then IDLE with busy=0.
- Timeout: withhold cdf_done -> ERROR exactly 16 cycles after entering CDF_WAIT, with timeout_error=1 and phase=7. A cdf_done arriving on cycle 16 instead -> MAP_START, no error. A later start_equalization -> CLEAR, timeout_error drops.
- Stray done: pulse histogram_done during CLEAR and during the HIST_START cycle -> ignored, FSM stays in HIST_WAIT. mapping_done during CDF_WAIT -> ignored.
- Abort while in CLEAR at address 3, and again while in MAP_WAIT -> IDLE next cycle, no equalization_done. Abort asserted together with start_equalization in ERROR -> IDLE.
- Assert reset asynchronously mid-HIST_WAIT, between clock edges -> outputs zero immediately. After release, a fresh start restarts clearing at address 0.
